// File: rtl/sram_ctrl.sv
// Sequences 2K x 8 async SRAM strobes from single-cycle requests; write busy WR_PULSE_CYCLES+3, read data valid RD_WAIT_CYCLES+1 cycles after accept.
// Backpressure: ready is high only in IDLE; a req while ready is low is dropped, never queued.
module sram_ctrl #(
    parameter int WR_PULSE_CYCLES = 2,
    parameter int RD_WAIT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [10:0] addrIn,
    input  logic [7:0]  wrData,
    output logic        ready,
    output logic        rdValid,
    output logic [7:0]  rdData,
    output logic [10:0] addr,
    output logic [7:0]  dataToSram,
    input  logic [7:0]  dataFromSram,
    output logic        chipEnable,
    output logic        writeEnable,
    output logic        outputEnable
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_SETUP  = 3'd1;
    localparam logic [2:0] WR_PULSE  = 3'd2;
    localparam logic [2:0] WR_HOLD   = 3'd3;
    localparam logic [2:0] RD_ACCESS = 3'd4;

    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] cnt;

    assign ready = (state == IDLE) && !reset;

    // Strobes are registered so no input can glitch them; chipEnable leads
    // writeEnable by the WR_SETUP cycle and trails it by the WR_HOLD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            chipEnable   <= 1'b1;
            writeEnable  <= 1'b1;
            outputEnable <= 1'b1;
            addr         <= 11'd0;
            dataToSram   <= 8'd0;
            rdData       <= 8'd0;
            rdValid      <= 1'b0;
        end else begin
            rdValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr       <= addrIn;
                        dataToSram <= wrData;
                        chipEnable <= 1'b0;
                        if (rw) begin
                            state <= WR_SETUP;
                        end else begin
                            outputEnable <= 1'b0;
                            cnt          <= RD_LOAD;
                            state        <= RD_ACCESS;
                        end
                    end
                end
                WR_SETUP: begin
                    writeEnable <= 1'b0;
                    cnt         <= WR_LOAD;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        writeEnable <= 1'b1;
                        state       <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    chipEnable <= 1'b1;
                    state      <= IDLE;
                end
                RD_ACCESS: begin
                    if (cnt == 4'd0) begin
                        rdData       <= dataFromSram;
                        rdValid      <= 1'b1;
                        chipEnable   <= 1'b1;
                        outputEnable <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    chipEnable   <= 1'b1;
                    writeEnable  <= 1'b1;
                    outputEnable <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default and 5/4 timing) each driving a behavioural SRAM.
module tb_sram_ctrl;

    localparam int WR0 = 2;
    localparam int RD0 = 2;
    localparam int WR1 = 5;
    localparam int RD1 = 4;
    localparam int QD  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;

    logic        req_s [2];
    logic        rw_s  [2];
    logic [10:0] ain_s [2];
    logic [7:0]  wd_s  [2];
    logic        rdy   [2];
    logic        rdv   [2];
    logic [7:0]  rdd   [2];
    logic [10:0] addr_o[2];
    logic [7:0]  dts   [2];
    logic [7:0]  dfs   [2];
    logic        ce_o  [2];
    logic        we_o  [2];
    logic        oe_o  [2];

    logic [7:0]  mem0 [2048];
    logic [7:0]  mem1 [2048];

    int tests = 0;
    int fails = 0;

    // Expectation queues (circular buffers) per instance
    int          ce_q  [2][QD];
    int          we_q  [2][QD];
    logic [7:0]  rd_dat[2][QD];
    int          rd_cyc[2][QD];
    int          ce_wp[2], ce_rp[2], we_wp[2], we_rp[2], rd_wp[2], rd_rp[2];

    int          ce_run[2], we_run[2];
    logic        prev_ce[2], prev_we[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl #(.WR_PULSE_CYCLES(WR0), .RD_WAIT_CYCLES(RD0)) u0 (
        .clk(clk), .reset(reset), .req(req_s[0]), .rw(rw_s[0]), .addrIn(ain_s[0]),
        .wrData(wd_s[0]), .ready(rdy[0]), .rdValid(rdv[0]), .rdData(rdd[0]),
        .addr(addr_o[0]), .dataToSram(dts[0]), .dataFromSram(dfs[0]),
        .chipEnable(ce_o[0]), .writeEnable(we_o[0]), .outputEnable(oe_o[0])
    );

    sram_ctrl #(.WR_PULSE_CYCLES(WR1), .RD_WAIT_CYCLES(RD1)) u1 (
        .clk(clk), .reset(reset), .req(req_s[1]), .rw(rw_s[1]), .addrIn(ain_s[1]),
        .wrData(wd_s[1]), .ready(rdy[1]), .rdValid(rdv[1]), .rdData(rdd[1]),
        .addr(addr_o[1]), .dataToSram(dts[1]), .dataFromSram(dfs[1]),
        .chipEnable(ce_o[1]), .writeEnable(we_o[1]), .outputEnable(oe_o[1])
    );

    // Behavioural SRAMs: write while CE and WE are low, drive data while CE and OE are low
    assign dfs[0] = (!ce_o[0] && !oe_o[0]) ? mem0[addr_o[0]] : 8'hEE;
    assign dfs[1] = (!ce_o[1] && !oe_o[1]) ? mem1[addr_o[1]] : 8'hEE;
    always @(posedge clk) if (!ce_o[0] && !we_o[0]) mem0[addr_o[0]] <= dts[0];
    always @(posedge clk) if (!ce_o[1] && !we_o[1]) mem1[addr_o[1]] <= dts[1];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wrp(input int i);
        return (i == 0) ? WR0 : WR1;
    endfunction

    function automatic int rdp(input int i);
        return (i == 0) ? RD0 : RD1;
    endfunction

    // Called just after the accepting edge: push the responses the op must produce
    task automatic expect_op(input int i, input logic w, input logic [7:0] rexp);
        if (w) begin
            ce_q[i][ce_wp[i] % QD] = wrp(i) + 2; ce_wp[i]++;
            we_q[i][we_wp[i] % QD] = wrp(i);     we_wp[i]++;
        end else begin
            ce_q[i][ce_wp[i] % QD]   = rdp(i);        ce_wp[i]++;
            rd_dat[i][rd_wp[i] % QD] = rexp;
            rd_cyc[i][rd_wp[i] % QD] = cyc + rdp(i);  rd_wp[i]++;
        end
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!rdy[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", int'(rdy[i]), 1);
    endtask

    task automatic issue(input int i, input logic w, input logic [10:0] a,
                         input logic [7:0] d, input logic [7:0] rexp);
        wait_ready(i);
        req_s[i] = 1'b1; rw_s[i] = w; ain_s[i] = a; wd_s[i] = d;
        @(posedge clk); #1;
        req_s[i] = 1'b0;
        expect_op(i, w, rexp);
        check("addr_latch", int'(addr_o[i]), int'(a));
        if (w) check("wdata_latch", int'(dts[i]), int'(d));
    endtask

    // Monitor: pops expectations when strobe runs end or rdValid pulses
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                ce_run[i] = 0; we_run[i] = 0;
                ce_rp[i] = ce_wp[i]; we_rp[i] = we_wp[i]; rd_rp[i] = rd_wp[i];
                check("rst_rdvalid", int'(rdv[i]), 0);
            end else begin
                if (!we_o[i]) check("we_oe_excl", int'(oe_o[i]), 1);
                if (!we_o[i] && prev_we[i]) check("we_fall_after_ce", int'(prev_ce[i]), 0);
                if (!ce_o[i]) ce_run[i]++;
                else if (ce_run[i] != 0) begin
                    if (ce_rp[i] == ce_wp[i]) check("ce_run_unexpected", ce_run[i], 0);
                    else begin check("ce_low_len", ce_run[i], ce_q[i][ce_rp[i] % QD]); ce_rp[i]++; end
                    ce_run[i] = 0;
                end
                if (!we_o[i]) we_run[i]++;
                else if (we_run[i] != 0) begin
                    if (we_rp[i] == we_wp[i]) check("we_run_unexpected", we_run[i], 0);
                    else begin check("we_low_len", we_run[i], we_q[i][we_rp[i] % QD]); we_rp[i]++; end
                    we_run[i] = 0;
                end
                if (rdv[i]) begin
                    if (rd_rp[i] == rd_wp[i]) check("rdvalid_unexpected", 1, 0);
                    else begin
                        check("rd_data", int'(rdd[i]), int'(rd_dat[i][rd_rp[i] % QD]));
                        check("rd_latency", cyc, rd_cyc[i][rd_rp[i] % QD]);
                        rd_rp[i]++;
                    end
                end
            end
            prev_ce[i] = ce_o[i];
            prev_we[i] = we_o[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [10:0] a;
        int          busy;
        for (int k = 0; k < 2048; k++) begin
            mem0[k] = 8'(k) ^ 8'h5A;
            mem1[k] = 8'(k) ^ 8'h5A;
        end
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; rw_s[i] = 1'b0; ain_s[i] = 11'd0; wd_s[i] = 8'd0;
            ce_wp[i] = 0; ce_rp[i] = 0; we_wp[i] = 0; we_rp[i] = 0; rd_wp[i] = 0; rd_rp[i] = 0;
            ce_run[i] = 0; we_run[i] = 0; prev_ce[i] = 1'b1; prev_we[i] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", int'(rdy[i]), 0);
            check("rst_strobes", int'({ce_o[i], we_o[i], oe_o[i]}), 7);
            check("rst_addr", int'(addr_o[i]), 0);
            check("rst_wdata", int'(dts[i]), 0);
            check("rst_rddata", int'(rdd[i]), 0);
        end
        reset = 1'b0;
        #1;
        check("ready_after_rst", int'(rdy[0]), 1);
        @(posedge clk); #1;

        // Basic write/read and address boundaries
        issue(0, 1'b1, 11'h000, 8'hA5, 8'h00);
        issue(0, 1'b0, 11'h000, 8'h00, 8'hA5);
        issue(0, 1'b1, 11'h7FF, 8'h3C, 8'h00);
        issue(0, 1'b1, 11'h000, 8'hC3, 8'h00);
        issue(0, 1'b0, 11'h7FF, 8'h00, 8'h3C);
        issue(0, 1'b0, 11'h000, 8'h00, 8'hC3);

        // req held high with alternating rw; accepted: k=0 W, 5 R, 8 W, 13 R, 16 W
        wait_ready(0);
        busy = 0;
        for (int k = 0; k < 18; k++) begin
            w = ~k[0];
            a = w ? 11'(32'h200 + k) : 11'(32'h200 + k - 5);
            req_s[0] = 1'b1; rw_s[0] = w; ain_s[0] = a; wd_s[0] = 8'(32'h60 + k);
            check("held_ready", int'(rdy[0]), int'(busy == 0));
            @(posedge clk); #1;
            if (busy == 0) begin
                expect_op(0, w, 8'(32'h60 + k - 5));
                check("held_addr", int'(addr_o[0]), int'(a));
                busy = w ? WR0 + 2 : RD0;
            end else begin
                busy--;
            end
        end
        req_s[0] = 1'b0;

        // req during WR_PULSE is ignored
        issue(0, 1'b1, 11'h050, 8'h11, 8'h00);
        @(posedge clk); #1;
        req_s[0] = 1'b1; rw_s[0] = 1'b1; ain_s[0] = 11'h3AA; wd_s[0] = 8'hFF;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        check("ignored_addr", int'(addr_o[0]), 'h050);
        check("ignored_wdata", int'(dts[0]), 'h11);
        issue(0, 1'b0, 11'h3AA, 8'h00, 8'hF0);
        issue(0, 1'b0, 11'h050, 8'h00, 8'h11);

        // Reset during the second WR_PULSE cycle
        issue(0, 1'b1, 11'h060, 8'h77, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_we", int'(we_o[0]), 1);
        check("abort_ce", int'(ce_o[0]), 1);
        check("abort_ready", int'(rdy[0]), 0);
        @(posedge clk); #1;
        check("abort_ready_hold", int'(rdy[0]), 0);
        reset = 1'b0;
        #1;
        check("ready_after_abort", int'(rdy[0]), 1);
        @(posedge clk); #1;
        issue(0, 1'b0, 11'h123, 8'h00, 8'h79);

        // Long-pulse instance
        issue(1, 1'b1, 11'h400, 8'h5E, 8'h00);
        issue(1, 1'b0, 11'h400, 8'h00, 8'h5E);
        issue(1, 1'b0, 11'h7FF, 8'h00, 8'hA5);

        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rd_q_drained", rd_wp[i] - rd_rp[i], 0);
            check("ce_q_drained", ce_wp[i] - ce_rp[i], 0);
            check("we_q_drained", we_wp[i] - we_rp[i], 0);
        end
        check("rddata_held", int'(rdd[1]), 'hA5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
